// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types and constants for the highway/farm-road traffic light controller.
// Contents: FSM state enum, default phase timings, per-state lamp vectors.
package traffic_light_pkg;

    localparam int unsigned MIN_GREEN_DEF  = 20;
    localparam int unsigned YELLOW_DEF     = 4;
    localparam int unsigned FARM_GREEN_DEF = 16;
    localparam int unsigned TIMER_W_DEF    = 8;

    typedef enum logic [1:0] {
        HG  = 2'd0,
        HY  = 2'd1,
        FGR = 2'd2,
        FYL = 2'd3
    } tl_state_e;

    // One lamp set, ordered {G, Y, R}
    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    typedef struct packed {
        logic [2:0] r1;
        logic [2:0] r2;
        logic [2:0] f;
    } tl_lamps_t;

    localparam tl_lamps_t LAMPS_HG  = '{r1: LAMP_G, r2: LAMP_G, f: LAMP_R};
    localparam tl_lamps_t LAMPS_HY  = '{r1: LAMP_Y, r2: LAMP_Y, f: LAMP_R};
    localparam tl_lamps_t LAMPS_FGR = '{r1: LAMP_R, r2: LAMP_R, f: LAMP_G};
    localparam tl_lamps_t LAMPS_FYL = '{r1: LAMP_R, r2: LAMP_R, f: LAMP_Y};

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Intersection I/O bundle: farm-road car sensor in, nine lamp drives out.
// master = intersection side (drives c), slave = controller (drives lamps).
interface traffic_light_ctrl_if;

    logic c;
    logic R1G, R1Y, R1R;
    logic R2G, R2Y, R2R;
    logic FG,  FY,  FR;

    modport master (
        output c,
        input  R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR
    );

    modport slave (
        input  c,
        output R1G, R1Y, R1R, R2G, R2Y, R2R, FG, FY, FR
    );

endinterface

// File: rtl/tl_phase_timer.sv
// Phase timer: counts cycles in the current phase.
// Ports: clk, rst_n (sync, active-high), clr_i (restart at 0 next cycle),
//        sat_i (hold once count reaches limit_i), limit_i, count_o.
module tl_phase_timer #(
    parameter int unsigned TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               sat_i,
    input  logic [TIMER_W-1:0] limit_i,
    output logic [TIMER_W-1:0] count_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Clear wins over saturation; saturation only holds at the limit
    always_comb begin
        count_d = count_q + TIMER_W'(1);
        if (clr_i) begin
            count_d = '0;
        end else if (sat_i && (count_q == limit_i)) begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Moore traffic light controller for a highway / farm-road intersection.
// Highway green by default; farm sensor c earns a farm-green phase once the
// minimum highway green has elapsed.
// Ports: clk, rst_n (sync, active-high despite the name), bus (slave side:
//        c in, R1*/R2*/F* lamps out, each a pure decode of the state register).
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = MIN_GREEN_DEF,
    parameter int unsigned YELLOW     = YELLOW_DEF,
    parameter int unsigned FARM_GREEN = FARM_GREEN_DEF,
    parameter int unsigned TIMER_W    = TIMER_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_light_ctrl_if.slave   bus
);

    localparam logic [TIMER_W-1:0] HG_LAST   = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] Y_LAST    = TIMER_W'(YELLOW - 1);
    localparam logic [TIMER_W-1:0] FG_LAST   = TIMER_W'(FARM_GREEN - 1);

    tl_state_e          state_q;
    tl_state_e          state_d;
    logic [TIMER_W-1:0] timer;
    logic               timer_clr;
    logic               timer_sat;
    tl_lamps_t          lamps;

    // Timer restarts on every state change and parks at the HG minimum
    assign timer_clr = (state_d != state_q);
    assign timer_sat = (state_q == HG);

    tl_phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (timer_clr),
        .sat_i   (timer_sat),
        .limit_i (HG_LAST),
        .count_o (timer)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= HG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HG:  if (bus.c && (timer == HG_LAST))        state_d = HY;
            HY:  if (timer == Y_LAST)                    state_d = FGR;
            FGR: if (!bus.c || (timer == FG_LAST))       state_d = FYL;
            FYL: if (timer == Y_LAST)                    state_d = HG;
            default:                                     state_d = HG;
        endcase
    end

    // Lamp decode
    always_comb begin
        lamps = LAMPS_HG;
        unique case (state_q)
            HG:      lamps = LAMPS_HG;
            HY:      lamps = LAMPS_HY;
            FGR:     lamps = LAMPS_FGR;
            FYL:     lamps = LAMPS_FYL;
            default: lamps = LAMPS_HG;
        endcase
    end

    assign bus.R1G = lamps.r1[2];
    assign bus.R1Y = lamps.r1[1];
    assign bus.R1R = lamps.r1[0];
    assign bus.R2G = lamps.r2[2];
    assign bus.R2Y = lamps.r2[1];
    assign bus.R2R = lamps.r2[0];
    assign bus.FG  = lamps.f[2];
    assign bus.FY  = lamps.f[1];
    assign bus.FR  = lamps.f[0];

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: expected lamp vectors are queued
// as each cycle's stimulus is driven and compared after the following edge.
module tb_traffic_light_ctrl;

    localparam int ST_HG  = 0;
    localparam int ST_HY  = 1;
    localparam int ST_FGR = 2;
    localparam int ST_FYL = 3;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [8:0] exp_q[$];

    traffic_light_ctrl_if bus ();

    traffic_light_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {R1G,R1Y,R1R, R2G,R2Y,R2R, FG,FY,FR}
    function automatic logic [8:0] lamps_of(input int st);
        case (st)
            ST_HG:   return 9'b100_100_001;
            ST_HY:   return 9'b010_010_001;
            ST_FGR:  return 9'b001_001_100;
            default: return 9'b001_001_010;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One cycle: drive inputs, queue the lamps expected after the edge, compare
    task automatic step(input string tag, input logic rst_v, input logic c_v,
                        input int st);
        logic [8:0] got;
        logic [8:0] exp;
        bus.c = c_v;
        rst_n = rst_v;
        exp_q.push_back(lamps_of(st));
        @(posedge clk);
        #1;
        got = {bus.R1G, bus.R1Y, bus.R1R, bus.R2G, bus.R2Y, bus.R2R,
               bus.FG, bus.FY, bus.FR};
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, 32'(got), 32'(exp));
        end
        check_eq({tag, "_r1_onehot"}, 32'($countones(got[8:6])), 32'd1);
        check_eq({tag, "_r2_onehot"}, 32'($countones(got[5:3])), 32'd1);
        check_eq({tag, "_f_onehot"},  32'($countones(got[2:0])), 32'd1);
        check_eq({tag, "_conflict"},
                 32'((got[2] | got[1]) & (got[8] | got[7] | got[5] | got[4])), 32'd0);
    endtask

    task automatic run(input string tag, input logic c_v, input int st, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, c_v, st);
    endtask

    task automatic reset_cycles(input string tag, input logic c_v, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, c_v, ST_HG);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        bus.c   = 1'b0;

        // Reset, then idle highway green
        reset_cycles("reset", 1'b0, 2);
        run("idle_hg", 1'b0, ST_HG, 200);

        // Full cycle twice with c held high from the cycle after reset
        reset_cycles("reset2", 1'b0, 1);
        run("c1_hg", 1'b1, ST_HG, 19);
        run("c1_hy", 1'b1, ST_HY, 4);
        run("c1_fgr", 1'b1, ST_FGR, 16);
        run("c1_fyl", 1'b1, ST_FYL, 4);
        run("c1_hg2", 1'b1, ST_HG, 20);
        run("c1_hy2", 1'b1, ST_HY, 4);
        run("c1_fgr2", 1'b1, ST_FGR, 16);
        run("c1_fyl2", 1'b1, ST_FYL, 4);

        // Minimum met, then c high for 14 cycles: FGR lasts 10
        run("pre14_hg", 1'b0, ST_HG, 30);
        run("c14_hy", 1'b1, ST_HY, 4);
        run("c14_fgr", 1'b1, ST_FGR, 10);
        run("c14_fyl", 1'b0, ST_FYL, 4);

        // Short pulse before minimum is lost
        run("pulse_pre", 1'b0, ST_HG, 3);
        run("pulse_on", 1'b1, ST_HG, 5);
        run("pulse_post", 1'b0, ST_HG, 40);

        // Reset mid-FGR, then full minimum again before HY
        run("rst_hy", 1'b1, ST_HY, 4);
        run("rst_fgr", 1'b1, ST_FGR, 5);
        reset_cycles("rst_mid", 1'b1, 6);
        run("rst_hg", 1'b1, ST_HG, 19);
        run("rst_hy2", 1'b1, ST_HY, 4);

        // c drops exactly as the farm maximum expires; c during FYL ignored
        run("max_fgr", 1'b1, ST_FGR, 16);
        step("max_drop", 1'b0, 1'b0, ST_FYL);
        run("max_fyl", 1'b1, ST_FYL, 3);
        run("max_hg", 1'b1, ST_HG, 20);
        run("max_hy", 1'b1, ST_HY, 1);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
